// File: rtl/clct_busy_marker_cclut_tmb.sv
// clct_busy_marker_cclut_tmb
// Marks the CFEB that holds an accepted best CLCT key as busy for a programmable
// number of clocks. The busy flags feed back into the ccLUT best-1-of-5 selector.
// Optional feature macro: BUSY_ADJ_SPILL_EN
//   When defined, a key near a CFEB edge also marks the neighbouring CFEB busy.
module clct_busy_marker_cclut_tmb #(
    parameter int MXPATB     = 6,
    parameter int MXKEYBX    = 8,
    parameter int MXCFEB     = 5,
    parameter int MXWINB     = 4,
    parameter int SPILL_ZONE = 2
) (
    input  logic              clock,
    input  logic              global_reset,
    input  logic              clct_accept,
    input  logic [MXPATB-1:0] best_pat,
    input  logic [MXKEYBX-1:0] best_key,
    input  logic              best_bsy,
    input  logic [MXWINB-1:0] busy_window,
    input  logic [MXPATB-2:0] pat_thresh,
    output logic              bsy0,
    output logic              bsy1,
    output logic              bsy2,
    output logic              bsy3,
    output logic              bsy4,
    output logic              busy_any,
    output logic              key_err,
    output logic [15:0]       claim_cnt
);

    localparam int LKEYB = MXKEYBX - 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } cfeb_state_t;

    // Saturating claim counter step; holds at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---- Stage p0: decode the accept strobe against the selector outputs ----
    logic [2:0]         cfeb_p0;
    logic               accept_vld_p0;
    logic               key_ok_p0;
    logic               claim_vld_p0;
    logic               bad_key_p0;
    logic [MXCFEB-1:0]  load_p0;
    logic               unused_pat_lsb;

    assign cfeb_p0        = best_key[MXKEYBX-1 -: 3];
    assign unused_pat_lsb = best_pat[0];
    assign accept_vld_p0  = clct_accept && !best_bsy
                            && (best_pat[MXPATB-1:1] >= pat_thresh)
                            && (busy_window != '0);
    assign key_ok_p0      = int'(cfeb_p0) < MXCFEB;
    assign claim_vld_p0   = accept_vld_p0 && key_ok_p0;
    assign bad_key_p0     = accept_vld_p0 && !key_ok_p0;

`ifdef BUSY_ADJ_SPILL_EN
    logic [LKEYB-1:0] lkey_p0;
    assign lkey_p0 = best_key[LKEYB-1:0];

    // Select which CFEB counters reload: the key CFEB plus an edge neighbour.
    always_comb begin
        load_p0 = '0;
        for (int i = 0; i < MXCFEB; i++) begin
            if (claim_vld_p0 && int'(cfeb_p0) == i)
                load_p0[i] = 1'b1;
            // Key close to the low edge spills into the CFEB below.
            if (claim_vld_p0 && int'(lkey_p0) < SPILL_ZONE && int'(cfeb_p0) == i + 1)
                load_p0[i] = 1'b1;
            // Key close to the high edge spills into the CFEB above, if one exists.
            if (claim_vld_p0 && int'(lkey_p0) >= (1 << LKEYB) - SPILL_ZONE
                && int'(cfeb_p0) + 1 == i)
                load_p0[i] = 1'b1;
        end
    end
`else
    logic [LKEYB-1:0] unused_lkey;
    assign unused_lkey = best_key[LKEYB-1:0];

    // Select which CFEB counter reloads: only the CFEB holding the key.
    always_comb begin
        load_p0 = '0;
        for (int i = 0; i < MXCFEB; i++) begin
            if (claim_vld_p0 && int'(cfeb_p0) == i)
                load_p0[i] = 1'b1;
        end
    end
`endif

    // ---- Stage p1: per-CFEB window counters and registered busy flags ----
    logic [MXWINB-1:0]  cnt_p1   [MXCFEB];
    logic [MXWINB-1:0]  cnt_nxt  [MXCFEB];
    cfeb_state_t        state    [MXCFEB];
    logic [MXCFEB-1:0]  bsy_nxt;
    logic [MXCFEB-1:0]  bsy_p1;

    // Next-state per CFEB: IDLE stays at zero, HOLD counts down, a load restarts the window.
    always_comb begin
        for (int i = 0; i < MXCFEB; i++) begin
            state[i]   = (cnt_p1[i] != '0) ? HOLD : IDLE;
            cnt_nxt[i] = cnt_p1[i];
            case (state[i])
                IDLE:    cnt_nxt[i] = '0;
                HOLD:    cnt_nxt[i] = cnt_p1[i] - MXWINB'(1);
                default: cnt_nxt[i] = '0;
            endcase
            if (load_p0[i])
                cnt_nxt[i] = busy_window;
            bsy_nxt[i] = (cnt_nxt[i] != '0);
        end
    end

    // Counter state register; reset clears any window in progress.
    always_ff @(posedge clock) begin
        if (global_reset) begin
            for (int i = 0; i < MXCFEB; i++)
                cnt_p1[i] <= '0;
        end else begin
            for (int i = 0; i < MXCFEB; i++)
                cnt_p1[i] <= cnt_nxt[i];
        end
    end

    // Busy flags, their OR, the sticky bad-key flag and the claim counter.
    always_ff @(posedge clock) begin
        if (global_reset) begin
            bsy_p1    <= '0;
            busy_any  <= 1'b0;
            key_err   <= 1'b0;
            claim_cnt <= '0;
        end else begin
            bsy_p1   <= bsy_nxt;
            busy_any <= |bsy_nxt;
            if (bad_key_p0)
                key_err <= 1'b1;
            if (claim_vld_p0)
                claim_cnt <= sat_inc16(claim_cnt);
        end
    end

    assign bsy0 = bsy_p1[0];
    assign bsy1 = bsy_p1[1];
    assign bsy2 = bsy_p1[2];
    assign bsy3 = bsy_p1[3];
    assign bsy4 = bsy_p1[4];

endmodule
